// File: rtl/alu_seq.sv
// Multi-cycle sequential ALU: single-cycle logic/arith ops, radix-2 Booth multiply and
// restoring divide. Results and flags are registered and only change when entering DONE.
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] acc_o,
  output logic [15:0] acc_hi_o,
  output logic        zero_o,
  output logic        neg_o,
  output logic        carry_o,
  output logic        ovf_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StExec = 3'd1;
  localparam logic [2:0] StMul  = 3'd2;
  localparam logic [2:0] StDiv  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpNot = 4'd5;
  localparam logic [3:0] OpShl = 4'd6;
  localparam logic [3:0] OpShr = 4'd7;
  localparam logic [3:0] OpSar = 4'd8;
  localparam logic [3:0] OpMul = 4'd9;
  localparam logic [3:0] OpDiv = 4'd10;

  logic [2:0]  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  // hi is one bit wider so Booth add/sub of a full-range multiplicand cannot overflow
  logic [16:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic        qm1_q, qm1_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        load, done_d;

  logic [15:0] acc_q, acc_hi_q;
  logic        zero_q, neg_q, carry_q, ovf_q, err_q, done_q;

  logic [15:0] res_acc, res_hi;
  logic        res_carry, res_ovf, res_err;

  logic [16:0] mcand, booth_sum, div_r, div_sub;

  assign mcand   = {a_q[15], a_q};
  assign div_r   = {hi_q[15:0], lo_q[15]};
  assign div_sub = div_r - {1'b0, b_q};

  always_comb begin
    booth_sum = hi_q;
    unique case ({lo_q[0], qm1_q})
      2'b01:   booth_sum = hi_q + mcand;
      2'b10:   booth_sum = hi_q - mcand;
      default: booth_sum = hi_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d  = op_i;
          a_d   = a_i;
          b_d   = b_i;
          cnt_d = '0;
          hi_d  = '0;
          qm1_d = 1'b0;
          if (op_i == OpMul) begin
            lo_d    = b_i;
            state_d = StMul;
          end else if (op_i == OpDiv) begin
            lo_d    = a_i;
            state_d = StDiv;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        load    = 1'b1;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StMul: begin
        if (cnt_q == 5'd16) begin
          load    = 1'b1;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          hi_d  = {booth_sum[16], booth_sum[16:1]};
          lo_d  = {booth_sum[0], lo_q[15:1]};
          qm1_d = lo_q[0];
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDiv: begin
        if (b_q == 16'h0000 || cnt_q == 5'd16) begin
          load    = 1'b1;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          if (!div_sub[16]) begin
            hi_d = div_sub;
            lo_d = {lo_q[14:0], 1'b1};
          end else begin
            hi_d = div_r;
            lo_d = {lo_q[14:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    res_acc   = '0;
    res_hi    = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    case (op_q)
      OpAdd: begin
        {res_carry, res_acc} = {1'b0, a_q} + {1'b0, b_q};
        res_ovf = (a_q[15] == b_q[15]) && (res_acc[15] != a_q[15]);
      end
      OpSub: begin
        res_acc   = a_q - b_q;
        res_carry = a_q < b_q;
        res_ovf   = (a_q[15] != b_q[15]) && (res_acc[15] != a_q[15]);
      end
      OpAnd: res_acc = a_q & b_q;
      OpOr:  res_acc = a_q | b_q;
      OpXor: res_acc = a_q ^ b_q;
      OpNot: res_acc = ~a_q;
      // Shifts carry an extra guard bit that ends up holding the last bit shifted out
      OpShl: {res_carry, res_acc} = {1'b0, a_q} << b_q[3:0];
      OpShr: {res_acc, res_carry} = {a_q, 1'b0} >> b_q[3:0];
      OpSar: {res_acc, res_carry} = $signed({a_q, 1'b0}) >>> b_q[3:0];
      OpMul: begin
        res_acc = lo_q;
        res_hi  = hi_q[15:0];
        res_ovf = hi_q[15:0] != {16{lo_q[15]}};
      end
      OpDiv: begin
        if (b_q == 16'h0000) begin
          res_acc = 16'hFFFF;
          res_hi  = a_q;
          res_err = 1'b1;
        end else begin
          res_acc = lo_q;
          res_hi  = hi_q[15:0];
        end
      end
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      acc_hi_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (load) begin
        acc_q    <= res_acc;
        acc_hi_q <= res_hi;
        zero_q   <= res_acc == 16'h0000;
        neg_q    <= res_acc[15];
        carry_q  <= res_carry;
        ovf_q    <= res_ovf;
        err_q    <= res_err;
      end
    end
  end

  assign acc_o    = acc_q;
  assign acc_hi_o = acc_hi_q;
  assign zero_o   = zero_q;
  assign neg_o    = neg_q;
  assign carry_o  = carry_q;
  assign ovf_o    = ovf_q;
  assign err_o    = err_q;
  assign done_o   = done_q;
  assign busy_o   = (state_q == StExec) || (state_q == StMul) || (state_q == StDiv);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected results, a monitor checks
// each done pulse for values, flags and latency.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  op_i = '0;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic [15:0] acc_o, acc_hi_o;
  logic        zero_o, neg_o, carry_o, ovf_o, busy_o, done_o, err_o;

  alu_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .acc_o    (acc_o),
    .acc_hi_o (acc_hi_o),
    .zero_o   (zero_o),
    .neg_o    (neg_o),
    .carry_o  (carry_o),
    .ovf_o    (ovf_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] acc;
    logic [15:0] hi;
    logic [4:0]  flags;  // {zero, neg, carry, ovf, err}
    int          done_edge;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("acc", {16'h0, acc_o}, {16'h0, mon_e.acc});
        check("acc_hi", {16'h0, acc_hi_o}, {16'h0, mon_e.hi});
        check("flags_znco_e", {27'h0, zero_o, neg_o, carry_o, ovf_o, err_o},
              {27'h0, mon_e.flags});
        check("latency_edge", edge_cnt, mon_e.done_edge);
      end
    end
  end

  task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] eacc, input logic [15:0] ehi, input logic [4:0] eflags,
                     input int lat, input bit disturb);
    exp_t e;
    int   busy_hi;
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(posedge clk);
    #1;
    e.acc       = eacc;
    e.hi        = ehi;
    e.flags     = eflags;
    e.done_edge = edge_cnt + lat;
    sb_q.push_back(e);
    start_i = 1'b0;
    a_i     = 16'hDEAD;
    b_i     = 16'hBEEF;
    busy_hi = 0;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #2;
      if (busy_o === 1'b1) busy_hi++;
      if (disturb && i == 3) begin
        start_i = 1'b1;
        op_i    = 4'd0;
        a_i     = 16'h1111;
      end
      if (disturb && i == 4) start_i = 1'b0;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
    check("busy_cycles", busy_hi, lat);
    @(negedge clk);
    check("hold_acc", {16'h0, acc_o}, {16'h0, eacc});
    check("idle_busy_done", {30'h0, busy_o, done_o}, 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {acc_o, acc_hi_o}, 32'd0);
    check({name, "_bits"}, {25'h0, zero_o, neg_o, carry_o, ovf_o, busy_o, done_o, err_o},
          32'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2 check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b1;

    //   op     a         b         acc       acc_hi    zncoe     lat
    run(4'd0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 5'b01010, 1, 1'b0);
    run(4'd1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 5'b01100, 1, 1'b0);
    run(4'd1, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 5'b10000, 1, 1'b0);
    run(4'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 5'b00000, 1, 1'b0);
    run(4'd3, 16'hF0F0, 16'h0F01, 16'hFFF1, 16'h0000, 5'b01000, 1, 1'b0);
    run(4'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 5'b10000, 1, 1'b0);
    run(4'd5, 16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 5'b01000, 1, 1'b0);
    run(4'd6, 16'h8001, 16'h0001, 16'h0002, 16'h0000, 5'b00100, 1, 1'b0);
    run(4'd6, 16'h1234, 16'hFFF0, 16'h1234, 16'h0000, 5'b00000, 1, 1'b0);
    run(4'd7, 16'hC001, 16'h000F, 16'h0001, 16'h0000, 5'b00100, 1, 1'b0);
    run(4'd8, 16'h8008, 16'h0004, 16'hF800, 16'h0000, 5'b01100, 1, 1'b0);
    run(4'd9, 16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF, 5'b01000, 17, 1'b0);
    run(4'd9, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 5'b10010, 17, 1'b0);
    run(4'd9, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 5'b10010, 17, 1'b0);
    run(4'd9, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 5'b00000, 17, 1'b1);
    run(4'd10, 16'd100, 16'd7, 16'd14, 16'd2, 5'b00000, 17, 1'b0);
    run(4'd10, 16'd100, 16'd0, 16'hFFFF, 16'd100, 5'b01001, 1, 1'b0);
    run(4'd11, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 5'b10001, 1, 1'b0);
    run(4'd10, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 5'b00000, 17, 1'b0);

    // Abort a divide mid-flight; outputs must clear without waiting for a clock edge.
    @(negedge clk);
    start_i = 1'b1;
    op_i    = 4'd10;
    a_i     = 16'd100;
    b_i     = 16'd7;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (3) begin
      @(negedge clk);
      check("done_in_reset", {31'h0, done_o}, 32'd0);
    end
    rst = 1'b1;
    run(4'd0, 16'd2, 16'd3, 16'd5, 16'd0, 5'b00000, 1, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
